// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

  localparam int NUM_OPND_MAX = 8;
  localparam int IDX_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_SHOW,
    ST_ERR
  } state_e;

  localparam logic [3:0] LED_IDLE  = 4'd0;
  localparam logic [3:0] LED_LOAD0 = 4'd1;
  localparam logic [3:0] LED_EXEC  = 4'd9;
  localparam logic [3:0] LED_SHOW  = 4'd10;
  localparam logic [3:0] LED_ERR   = 4'd15;

  function automatic logic [3:0] load_led(input logic [IDX_W-1:0] idx);
    return LED_LOAD0 + {1'b0, idx};
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Two-flop synchroniser plus rising-edge detector for a raw button; one-cycle pulse out.
// Pulses are suppressed until the pipeline holds real samples, so a button held through reset never fires.
module btn_pulse (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] warm_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      warm_q <= 2'd0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // s3_q holds a genuine post-reset sample only once warm_q saturates
  assign pulse_o = s2_q & ~s3_q & (warm_q == 2'd3);

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing FSM: IDLE -> LOAD[0..NUM_OPND-1] -> EXEC -> SHOW, chained reuse of the result.
// Define CALC_OVF_ERR_EN to route an overflowing ALU result into the ERR state.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int NUM_OPND = 2,
  parameter int OPW      = 2
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                enter,
  input  logic [OPW-1:0]      op_sel,
  input  logic                alu_done,
  input  logic                alu_ovf,
  output logic                reset_dp,
  output logic [NUM_OPND-1:0] ld_opnd,
  output logic                ld_r,
  output logic [OPW-1:0]      op,
  output logic                alu_start,
  output logic                ld_ou,
  output logic                iu_au,
  output logic                chain,
  output logic [3:0]          state_led,
  output logic                err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPND - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             chain_q, chain_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             alu_start_q, alu_start_d;
  logic             ld_r_q, ld_r_d;
  logic             enter_p;
  logic             ovf_err;

  btn_pulse u_btn (
    .clk_i   (clock),
    .rst_n_i (clear),
    .btn_i   (enter),
    .pulse_o (enter_p)
  );

`ifdef CALC_OVF_ERR_EN
  assign ovf_err = alu_ovf;
`else
  logic ovf_unused;
  assign ovf_unused = alu_ovf;
  assign ovf_err    = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      chain_q     <= 1'b0;
      op_q        <= '0;
      alu_start_q <= 1'b0;
      ld_r_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chain_q     <= chain_d;
      op_q        <= op_d;
      alu_start_q <= alu_start_d;
      ld_r_q      <= ld_r_d;
    end
  end

  // alu_start and ld_r are registered so they land in the first EXEC / first SHOW cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    chain_d     = chain_q;
    op_d        = op_q;
    alu_start_d = 1'b0;
    ld_r_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enter_p) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (enter_p) begin
          if (idx_q == LAST_IDX) begin
            state_d     = ST_EXEC;
            alu_start_d = 1'b1;
            op_d        = op_sel;
          end else begin
            idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_EXEC: begin
        if (alu_done) begin
          if (ovf_err) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_SHOW;
            ld_r_d  = 1'b1;
          end
        end
      end
      ST_SHOW: begin
        if (enter_p) begin
          state_d = ST_LOAD;
          idx_d   = {{(IDX_W-1){1'b0}}, 1'b1};
          chain_d = 1'b1;
        end
      end
      ST_ERR: begin
        if (enter_p) begin
          state_d = ST_IDLE;
          chain_d = 1'b0;
          op_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        chain_d = 1'b0;
        op_d    = '0;
      end
    endcase
  end

  always_comb begin
    reset_dp  = 1'b0;
    ld_opnd   = '0;
    ld_ou     = 1'b0;
    iu_au     = 1'b0;
    state_led = LED_IDLE;
    case (state_q)
      ST_IDLE: begin
        reset_dp = 1'b1;
        iu_au    = 1'b1;
      end
      ST_LOAD: begin
        ld_opnd   = NUM_OPND'(1) << idx_q;
        ld_ou     = 1'b1;
        iu_au     = 1'b1;
        state_led = load_led(idx_q);
      end
      ST_EXEC: state_led = LED_EXEC;
      ST_SHOW: begin
        ld_ou     = 1'b1;
        state_led = LED_SHOW;
      end
      ST_ERR:  state_led = LED_ERR;
      default: begin
        reset_dp = 1'b1;
        iu_au    = 1'b1;
      end
    endcase
  end

`ifdef CALC_OVF_ERR_EN
  assign err = (state_q == ST_ERR);
`else
  assign err = 1'b0;
`endif

  assign op        = op_q;
  assign chain     = chain_q;
  assign alu_start = alu_start_q;
  assign ld_r      = ld_r_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: vector table with a scoreboard queue, plus hand-written corner sequences.
module tb_calc_seq_ctrl;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       enter = 1'b0;
  logic       enter4 = 1'b0;
  logic       alu_done = 1'b0;
  logic       alu_done4 = 1'b0;
  logic       alu_ovf = 1'b0;
  logic [1:0] op_sel = 2'd0;

  logic       reset_dp, ld_r, alu_start, ld_ou, iu_au, chain, err;
  logic [1:0] ld_opnd, op;
  logic [3:0] state_led;

  logic       reset_dp4, ld_r4, alu_start4, ld_ou4, iu_au4, chain4, err4;
  logic [3:0] ld_opnd4, state_led4;
  logic [1:0] op4;

  int n_chk = 0;
  int n_pass = 0;
  int n_start = 0;
  int n_ldr = 0;

  always #5 clock = ~clock;

  calc_seq_ctrl #(.NUM_OPND(2), .OPW(2)) dut (
    .clock(clock), .clear(clear), .enter(enter), .op_sel(op_sel),
    .alu_done(alu_done), .alu_ovf(alu_ovf),
    .reset_dp(reset_dp), .ld_opnd(ld_opnd), .ld_r(ld_r), .op(op),
    .alu_start(alu_start), .ld_ou(ld_ou), .iu_au(iu_au), .chain(chain),
    .state_led(state_led), .err(err)
  );

  calc_seq_ctrl #(.NUM_OPND(4), .OPW(2)) dut4 (
    .clock(clock), .clear(clear), .enter(enter4), .op_sel(op_sel),
    .alu_done(alu_done4), .alu_ovf(alu_ovf),
    .reset_dp(reset_dp4), .ld_opnd(ld_opnd4), .ld_r(ld_r4), .op(op4),
    .alu_start(alu_start4), .ld_ou(ld_ou4), .iu_au(iu_au4), .chain(chain4),
    .state_led(state_led4), .err(err4)
  );

  // Pulse counters: a pulse wider than one cycle shows up as an extra count
  always @(negedge clock) begin
    if (alu_start === 1'b1) n_start++;
    if (ld_r === 1'b1) n_ldr++;
  end

  typedef struct {
    int         act;   // 0 = enter press, 1 = alu_done pulse after 5 idle cycles
    logic [1:0] opsel;
    logic       ovf;
    logic [3:0] led;
    logic [1:0] ldo;
    logic       rdp;
    logic       ch;
    logic       iu;
    logic       lou;
    logic [1:0] op;
    logic       err;
    int         st;    // cumulative alu_start pulses
    int         lr;    // cumulative ld_r pulses
  } vec_t;

  vec_t tbl[13];
  vec_t exp_q[$];
  vec_t e;

  function automatic vec_t mk(int act, int opsel, int ovf, int led, int ldo, int rdp, int ch,
                              int iu, int lou, int opv, int errv, int st, int lr);
    vec_t v;
    v.act = act; v.opsel = 2'(opsel); v.ovf = 1'(ovf); v.led = 4'(led); v.ldo = 2'(ldo);
    v.rdp = 1'(rdp); v.ch = 1'(ch); v.iu = 1'(iu); v.lou = 1'(lou); v.op = 2'(opv);
    v.err = 1'(errv); v.st = st; v.lr = lr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, expv);
  endtask

  task automatic press(input bit four);
    if (four) enter4 = 1'b1; else enter = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    if (four) enter4 = 1'b0; else enter = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic done_pulse(input logic ovf);
    repeat (5) @(posedge clock);
    #1;
    alu_done = 1'b1;
    alu_ovf  = ovf;
    @(posedge clock);
    #1;
    alu_done = 1'b0;
    alu_ovf  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    @(posedge clock);
    #1;
    clear = 1'b1;
    repeat (5) @(posedge clock);
    #1;
  endtask

  initial begin
    int base_s, base_l;

    tbl[0]  = mk(0, 0, 0,  1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  2, 2, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 2, 0,  9, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    tbl[3]  = mk(0, 3, 0,  9, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    tbl[4]  = mk(1, 3, 0, 10, 0, 0, 0, 0, 1, 2, 0, 1, 1);
    tbl[5]  = mk(1, 0, 0, 10, 0, 0, 0, 0, 1, 2, 0, 1, 1);
    tbl[6]  = mk(0, 0, 0,  2, 2, 0, 1, 1, 1, 2, 0, 1, 1);
    tbl[7]  = mk(0, 1, 0,  9, 0, 0, 1, 0, 0, 1, 0, 2, 1);
    tbl[8]  = mk(1, 0, 0, 10, 0, 0, 1, 0, 1, 1, 0, 2, 2);
    tbl[9]  = mk(0, 0, 0,  2, 2, 0, 1, 1, 1, 1, 0, 2, 2);
    tbl[10] = mk(0, 3, 0,  9, 0, 0, 1, 0, 0, 3, 0, 3, 2);
`ifdef CALC_OVF_ERR_EN
    tbl[11] = mk(1, 0, 1, 15, 0, 0, 1, 0, 0, 3, 1, 3, 2);
    tbl[12] = mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0, 3, 2);
`else
    tbl[11] = mk(1, 0, 1, 10, 0, 0, 1, 0, 1, 3, 0, 3, 3);
    tbl[12] = mk(0, 0, 0,  2, 2, 0, 1, 1, 1, 3, 0, 3, 3);
`endif

    // Outputs while clear is held low
    #23;
    check("rst_reset_dp", reset_dp, 1);
    check("rst_iu_au", iu_au, 1);
    check("rst_led", state_led, 0);
    check("rst_ld_opnd", ld_opnd, 0);
    check("rst_ld_r", ld_r, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_ld_ou", ld_ou, 0);
    check("rst_chain", chain, 0);
    check("rst_op", op, 0);
    check("rst_err", err, 0);
    check("rst4_reset_dp", reset_dp4, 1);
    check("rst4_iu_au", iu_au4, 1);
    check("rst4_led", state_led4, 0);
    check("rst4_ld_opnd", ld_opnd4, 0);
    check("rst4_misc", {ld_r4, alu_start4, ld_ou4, chain4, err4, op4}, 0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    // Advance lands on exactly the third edge after enter is first sampled
    enter = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("edge2_no_adv", state_led, 0);
    @(posedge clock);
    #1;
    check("edge3_adv", state_led, 1);
    enter = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("single_adv", state_led, 1);
    do_reset();

    base_s = n_start;
    base_l = n_ldr;
    for (int i = 0; i < 13; i++) begin
      op_sel = tbl[i].opsel;
      exp_q.push_back(tbl[i]);
      if (tbl[i].act == 0) press(1'b0);
      else done_pulse(tbl[i].ovf);
      e = exp_q.pop_front();
      check($sformatf("r%0d_led", i), state_led, e.led);
      check($sformatf("r%0d_ld_opnd", i), ld_opnd, e.ldo);
      check($sformatf("r%0d_reset_dp", i), reset_dp, e.rdp);
      check($sformatf("r%0d_chain", i), chain, e.ch);
      check($sformatf("r%0d_iu_au", i), iu_au, e.iu);
      check($sformatf("r%0d_ld_ou", i), ld_ou, e.lou);
      check($sformatf("r%0d_op", i), op, e.op);
      check($sformatf("r%0d_err", i), err, e.err);
      check($sformatf("r%0d_starts", i), n_start - base_s, e.st);
      check($sformatf("r%0d_ldr", i), n_ldr - base_l, e.lr);
    end

    // alu_done and enter_p in the same EXEC cycle: alu_done wins, press is lost
    do_reset();
    press(1'b0);
    press(1'b0);
    press(1'b0);
    check("coll_exec", state_led, 9);
    base_l = n_ldr;
    enter = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    alu_done = 1'b1;
    @(posedge clock);
    #1;
    alu_done = 1'b0;
    enter = 1'b0;
    check("coll_show", state_led, 10);
    repeat (4) @(posedge clock);
    #1;
    check("coll_drop", state_led, 10);
    check("coll_ldr", n_ldr - base_l, 1);

    // clear mid-EXEC, then enter held across release
    op_sel = 2'd1;
    press(1'b0);
    press(1'b0);
    check("mid_exec", state_led, 9);
    check("mid_op", op, 1);
    repeat (2) @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    check("clr_led", state_led, 0);
    check("clr_reset_dp", reset_dp, 1);
    check("clr_chain", chain, 0);
    check("clr_op", op, 0);
    enter = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("held_no_adv", state_led, 0);
    enter = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    press(1'b0);
    check("post_rel_press", state_led, 1);

    // NUM_OPND=4 walk, then a press inside EXEC
    for (int k = 0; k < 5; k++) begin
      int led_e;
      logic [3:0] ldo_e;
      led_e = (k < 4) ? k + 1 : 9;
      ldo_e = (k < 4) ? 4'(1 << k) : 4'd0;
      press(1'b1);
      check($sformatf("n4_led%0d", k), state_led4, led_e);
      check($sformatf("n4_ldo%0d", k), ld_opnd4, ldo_e);
    end
    press(1'b1);
    check("n4_exec_ign", state_led4, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_OPND, default 2, number of operand-load states (legal 2..8).
REQ-002 SHALL have parameter OPW, default 2, width of operation code passed to datapath.
REQ-003 SHALL have ports: clock in 1 system clock; clear in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: enter in 1 raw user button, asynchronous, level; op_sel in OPW requested operation (generalises add/sub).
REQ-005 SHALL have ports: alu_done in 1 datapath result valid; alu_ovf in 1 overflow flag, qualified by alu_done.
REQ-006 SHALL have outputs: reset_dp 1 datapath clear; ld_opnd NUM_OPND one-hot operand-register load; ld_r 1 result load; op OPW latched operation.
REQ-007 SHALL have outputs: alu_start 1 one-cycle ALU start pulse; ld_ou 1 output-unit load; iu_au 1 display mux (1=input unit, 0=ALU); chain 1 operand 0 sourced from result; state_led 4 encoded state; err 1 error indicator.

Function
REQ-008 SHALL synchronise enter through two flops, then detect rising edge, giving one-cycle enter_p; state advances on the third rising clock edge after enter is first sampled high.
REQ-009 SHALL be synchronous to clock; enter_p is the only user advance event (no clocking on enter).
REQ-010 SHALL implement states IDLE, LOAD[0..NUM_OPND-1], EXEC, SHOW, ERR.
REQ-011 IDLE: reset_dp=1, iu_au=1, all other outputs 0; enter_p -> LOAD[0].
REQ-012 LOAD[i]: ld_opnd[i]=1, ld_ou=1, iu_au=1; enter_p -> LOAD[i+1], or EXEC from LOAD[NUM_OPND-1].
REQ-013 EXEC entry SHALL latch op_sel into op and assert alu_start for exactly the first EXEC cycle; op stable until next EXEC entry.
REQ-014 EXEC SHALL wait for alu_done; on alu_done: ld_r=1 for that cycle, -> SHOW next edge; enter_p in EXEC ignored.
REQ-015 SHOW: ld_ou=1, iu_au=0; enter_p -> LOAD[1] with chain=1 (result reused as operand 0); chain cleared on entering IDLE.
REQ-016 alu_done outside EXEC SHALL be ignored; alu_done in same cycle as enter_p in EXEC: alu_done wins, enter_p dropped.
REQ-017 state_led: IDLE=0, LOAD[i]=1+i, EXEC=9, SHOW=10, ERR=15.
REQ-018 All outputs SHALL be registered or decoded from state register only (no input-to-output combinational paths except none).

Reset
REQ-019 clear low SHALL force IDLE, chain=0, op=0, synchroniser flops=0 asynchronously, including mid-EXEC.
REQ-020 During reset outputs SHALL be: reset_dp=1, iu_au=1, all others 0, state_led=0.
REQ-021 After clear release, an enter already held high SHALL NOT produce enter_p.

Configuration
REQ-022 With CALC_OVF_ERR_EN defined: alu_done with alu_ovf in EXEC -> ERR (ld_r=0, err=1, ld_ou=0, iu_au=0); enter_p in ERR -> IDLE.
REQ-023 Without CALC_OVF_ERR_EN: alu_ovf ignored, ERR unreachable, err tied 0.

Structure
REQ-024 Shared package calc_pkg SHALL hold state enum, state_led codes, and NUM_OPND max constant.
REQ-025 Synchroniser plus edge detect SHALL be sub-module btn_pulse (in enter, out one-cycle pulse).

Verification
REQ-026 clear low, enter pulses x3 (NUM_OPND=2) -> ld_opnd 01, 10, then EXEC with alu_start single cycle, state_led 1,2,9.
REQ-027 In EXEC, op_sel=2, alu_done after 5 cycles -> op=2 throughout, ld_r one cycle, SHOW state_led=10, iu_au=0.
REQ-028 In SHOW, enter -> LOAD[1], chain=1, ld_opnd=10; completing cycle returns to SHOW.
REQ-029 clear asserted mid-EXEC -> immediate IDLE, reset_dp=1; enter held across release -> no advance.
REQ-030 CALC_OVF_ERR_EN defined, alu_done+alu_ovf -> ERR, err=1, state_led=15; enter -> IDLE. Undefined: same stimulus -> SHOW.
REQ-031 NUM_OPND=4: five enter pulses -> LOAD[0..3] then EXEC; enter during EXEC ignored.
